// File: rtl/seg_scan_6digit.sv
// Six-digit multiplexed seven-segment driver for a common-anode display.
// Inputs are latched once per frame so a scan never shows a mix of old and new values.
module seg_scan_6digit #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned DIGIT_HZ  = 1200,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] digit_data,
  input  logic [5:0]  digit_en,
  input  logic [5:0]  dp_en,
  output logic        frame_done,
  output logic [5:0]  seg_sel,
  output logic [7:0]  seg_data
);

  localparam int unsigned DIV = CLK_FREQ / DIGIT_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt_q;
  logic [2:0]    idx_q;
  logic [23:0]   shadow_data_q;
  logic [5:0]    shadow_en_q;
  logic [5:0]    shadow_dp_q;
  logic          capture;
  logic          slot_end;
  logic [3:0]    cur_nibble;
  logic [5:0]    sel_d;
  logic [7:0]    data_d;

  function automatic logic [6:0] dec7(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign capture  = (div_cnt_q == '0) && (idx_q == 3'd0);
  assign slot_end = (div_cnt_q == CW'(DIV - 1));

  always_comb begin
    cur_nibble = '0;
    unique case (idx_q)
      3'd0:    cur_nibble = shadow_data_q[3:0];
      3'd1:    cur_nibble = shadow_data_q[7:4];
      3'd2:    cur_nibble = shadow_data_q[11:8];
      3'd3:    cur_nibble = shadow_data_q[15:12];
      3'd4:    cur_nibble = shadow_data_q[19:16];
      default: cur_nibble = shadow_data_q[23:20];
    endcase
  end

  // Blank the first BLANK_CYC clocks of each slot so the previous digit's drive decays.
  always_comb begin
    sel_d  = 6'h3F;
    data_d = 8'hFF;
    if ((div_cnt_q >= CW'(BLANK_CYC)) && shadow_en_q[idx_q]) begin
      sel_d  = ~(6'b000001 << idx_q);
      data_d = {~shadow_dp_q[idx_q], dec7(cur_nibble)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      idx_q         <= 3'd0;
      shadow_data_q <= '0;
      shadow_en_q   <= '0;
      shadow_dp_q   <= '0;
      frame_done    <= 1'b0;
      seg_sel       <= 6'h3F;
      seg_data      <= 8'hFF;
    end else begin
      if (slot_end) begin
        div_cnt_q <= '0;
        idx_q     <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end else begin
        div_cnt_q <= div_cnt_q + CW'(1);
      end
      if (capture) begin
        shadow_data_q <= digit_data;
        shadow_en_q   <= digit_en;
        shadow_dp_q   <= dp_en;
      end
      frame_done <= capture;
      seg_sel    <= sel_d;
      seg_data   <= data_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_6digit.sv
// Self-checking bench for seg_scan_6digit: per-cycle comparison against a slot/phase
// arithmetic model, plus fixed expectations for the directed scenarios.
module tb_seg_scan_6digit;

  localparam int unsigned CLK_FREQ  = 60;
  localparam int unsigned DIGIT_HZ  = 10;
  localparam int unsigned BLANK_CYC = 1;
  localparam int          DIV       = CLK_FREQ / DIGIT_HZ;
  localparam int          FRAME     = 6 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] digit_data = 24'h0;
  logic [5:0]  digit_en = 6'h0;
  logic [5:0]  dp_en = 6'h0;
  logic        frame_done;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: t is the number of non-reset clocks since the last reset, i.e. the
  // position within the scan that the next rising edge will act on.
  int         t = 0;
  logic [3:0] m_nib [6];
  logic       m_en  [6];
  logic       m_dp  [6];
  logic [5:0] e_sel;
  logic [7:0] e_data;
  logic       e_fd;
  int         o_slot;
  int         o_phase;
  int         o_t;

  logic [7:0] dec_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [5:0] sel_tbl [6]  = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
  logic [7:0] scan0_tbl [6] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};
  logic [7:0] scan1_tbl [6] = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan_6digit #(
    .CLK_FREQ (CLK_FREQ),
    .DIGIT_HZ (DIGIT_HZ),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digit_data(digit_data),
    .digit_en  (digit_en),
    .dp_en     (dp_en),
    .frame_done(frame_done),
    .seg_sel   (seg_sel),
    .seg_data  (seg_data)
  );

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 6; k++) begin
      m_nib[k] = 4'h0;
      m_en[k]  = 1'b0;
      m_dp[k]  = 1'b0;
    end
  end

  // One clock: apply the display rules to the position the edge acts on, then land on
  // the falling edge where outputs are sampled. o_* describe what the outputs now show.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      t = 0;
      e_sel = 6'h3F;
      e_data = 8'hFF;
      e_fd = 1'b0;
      o_t = -1;
      o_slot = -1;
      o_phase = -1;
    end else begin
      o_t = t;
      o_slot = (t / DIV) % 6;
      o_phase = t % DIV;
      if (o_phase < BLANK_CYC || !m_en[o_slot]) begin
        e_sel = 6'h3F;
        e_data = 8'hFF;
      end else begin
        e_sel = 6'h3F & ~(6'h01 << o_slot);
        e_data = dec_tbl[m_nib[o_slot]];
        if (m_dp[o_slot]) e_data[7] = 1'b0;
      end
      e_fd = (t % FRAME) == 0;
      if (e_fd) begin
        for (int k = 0; k < 6; k++) begin
          m_nib[k] = digit_data[4*k +: 4];
          m_en[k]  = digit_en[k];
          m_dp[k]  = dp_en[k];
        end
      end
      t++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    digit_data = 24'hABCDEF;
    digit_en = 6'h3F;
    dp_en = 6'h3F;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (seg_sel !== 6'h3F || seg_data !== 8'hFF || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got sel=%h data=%h fd=%b, want sel=3f data=ff fd=0",
                 i, seg_sel, seg_data, frame_done);
      end
    end
  endtask

  task automatic test_normal_scan();
    digit_data = 24'h543210;
    digit_en = 6'h3F;
    dp_en = 6'h00;
    rst = 1'b0;
    for (int k = 0; k < 2 * FRAME + 1; k++) begin
      step();
      n_tests++;
      if (frame_done !== ((k % FRAME) == 0)) begin
        n_fail++;
        $display("FAIL scan_fd[%0d]: got fd=%b, want %b", k, frame_done, (k % FRAME) == 0);
      end
      if ((k % DIV) >= BLANK_CYC) begin
        n_tests++;
        if (seg_sel !== sel_tbl[(k / DIV) % 6] || seg_data !== scan0_tbl[(k / DIV) % 6]) begin
          n_fail++;
          $display("FAIL scan[%0d]: got sel=%h data=%h, want sel=%h data=%h", k, seg_sel,
                   seg_data, sel_tbl[(k / DIV) % 6], scan0_tbl[(k / DIV) % 6]);
        end
      end else begin
        n_tests++;
        if (seg_sel !== 6'h3F || seg_data !== 8'hFF) begin
          n_fail++;
          $display("FAIL scan_blank[%0d]: got sel=%h data=%h, want sel=3f data=ff", k, seg_sel,
                   seg_data);
        end
      end
    end
  endtask

  task automatic test_mid_frame();
    int guard;
    int frame_idx;
    guard = 0;
    while (!(((t % FRAME) / DIV) == 2 && (t % DIV) == 2) && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    digit_data = 24'hFEDCBA;
    frame_idx = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      if (o_t % FRAME == 0) frame_idx++;
      if (frame_idx > 1) break;
      n_tests++;
      if (seg_sel !== e_sel || seg_data !== e_data || frame_done !== e_fd) begin
        n_fail++;
        $display("FAIL mid_model[t=%0d]: got sel=%h data=%h fd=%b, want sel=%h data=%h fd=%b",
                 o_t, seg_sel, seg_data, frame_done, e_sel, e_data, e_fd);
      end
      if (o_phase == DIV - 1) begin
        n_tests++;
        if (frame_idx == 0 && seg_data !== scan0_tbl[o_slot]) begin
          n_fail++;
          $display("FAIL mid_old[slot %0d]: got data=%h, want %h", o_slot, seg_data,
                   scan0_tbl[o_slot]);
        end else if (frame_idx == 1 && seg_data !== scan1_tbl[o_slot]) begin
          n_fail++;
          $display("FAIL mid_new[slot %0d]: got data=%h, want %h", o_slot, seg_data,
                   scan1_tbl[o_slot]);
        end
      end
    end
  endtask

  task automatic test_enables_dp();
    logic [5:0] want_sel;
    logic [7:0] want_data;
    digit_en = 6'b000011;
    dp_en = 6'b000010;
    digit_data = 24'h000010;
    for (int k = 0; k < 2 * FRAME && (t % FRAME) != 0; k++) step();
    step();
    for (int k = 0; k < FRAME; k++) begin
      step();
      want_sel = 6'h3F;
      want_data = 8'hFF;
      if (o_phase >= BLANK_CYC && o_slot == 0) begin
        want_sel = 6'h3E;
        want_data = 8'hC0;
      end else if (o_phase >= BLANK_CYC && o_slot == 1) begin
        want_sel = 6'h3D;
        want_data = 8'h79;
      end
      n_tests++;
      if (seg_sel !== want_sel || seg_data !== want_data) begin
        n_fail++;
        $display("FAIL en_dp[slot %0d ph %0d]: got sel=%h data=%h, want sel=%h data=%h",
                 o_slot, o_phase, seg_sel, seg_data, want_sel, want_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2 * FRAME && !(((t % FRAME) / DIV) == 3 && (t % DIV) == 2); k++) step();
    rst = 1'b1;
    step();
    n_tests++;
    if (seg_sel !== 6'h3F || seg_data !== 8'hFF || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got sel=%h data=%h fd=%b, want sel=3f data=ff fd=0",
               seg_sel, seg_data, frame_done);
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (frame_done !== 1'b1 || seg_sel !== 6'h3F || seg_data !== 8'hFF) begin
      n_fail++;
      $display("FAIL rst_recap: got sel=%h data=%h fd=%b, want sel=3f data=ff fd=1",
               seg_sel, seg_data, frame_done);
    end
    step();
    n_tests++;
    if (seg_sel !== 6'h3E || seg_data !== 8'hC0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_slot0: got sel=%h data=%h fd=%b, want sel=3e data=c0 fd=0",
               seg_sel, seg_data, frame_done);
    end
    for (int k = 0; k < FRAME; k++) begin
      step();
      n_tests++;
      if (seg_sel !== e_sel || seg_data !== e_data || frame_done !== e_fd) begin
        n_fail++;
        $display("FAIL rst_model[t=%0d]: got sel=%h data=%h fd=%b, want sel=%h data=%h fd=%b",
                 o_t, seg_sel, seg_data, frame_done, e_sel, e_data, e_fd);
      end
    end
  endtask

  task automatic test_random_invariants();
    for (int k = 0; k < 10 * FRAME; k++) begin
      digit_data = 24'($urandom);
      digit_en = 6'($urandom);
      dp_en = 6'($urandom);
      step();
      n_tests++;
      if (seg_sel !== e_sel || seg_data !== e_data || frame_done !== e_fd) begin
        n_fail++;
        $display("FAIL rand_model[t=%0d]: got sel=%h data=%h fd=%b, want sel=%h data=%h fd=%b",
                 o_t, seg_sel, seg_data, frame_done, e_sel, e_data, e_fd);
      end
      n_tests++;
      if ($countones(~seg_sel) > 1 || (seg_sel === 6'h3F && seg_data !== 8'hFF)) begin
        n_fail++;
        $display("FAIL rand_invariant[t=%0d]: got sel=%h data=%h, want <=1 select low, ff if idle",
                 o_t, seg_sel, seg_data);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_normal_scan();
    test_mid_frame();
    test_enables_dp();
    test_reset_mid();
    test_random_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_scan_6digit.md
Name: seg_scan_6digit

Overview:
- Six-digit, time-multiplexed seven-segment driver.
- Sits directly downstream of the key-debounce/counter logic: takes six 4-bit hex values plus per-digit enable and decimal-point flags, and drives the board's common-anode display.
- Produces the active-low seg_sel[5:0] and seg_data[7:0] buses.
- Latches inputs once per frame so a display never tears mid-scan, and reports each latch with a one-cycle pulse.

Parameters:
CLK_FREQ, 50000000, clk frequency in Hz
DIGIT_HZ, 1200, digit-slot switch rate; DIV = CLK_FREQ/DIGIT_HZ clocks per slot (41666 at defaults)
BLANK_CYC, 16, clocks at the start of each slot with all digits off (anti-ghosting); must satisfy BLANK_CYC < DIV

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous active-high reset
digit_data  input  24  six hex nibbles; [3:0] = digit 0 (rightmost), [23:20] = digit 5
digit_en  input  6  1 = digit shown; 0 = digit blanked
dp_en  input  6  1 = decimal point lit on that digit
frame_done  output  1  one-cycle pulse when the shadow registers latch new inputs
seg_sel  output  6  active-low digit select; bit i drives digit i
seg_data  output  8  active-low segments; [7] = dp, [6:0] = g..a

Behaviour:
- All state advances on the rising edge of clk. rst is sampled synchronously and overrides everything else.
- Reset values:
  - div_cnt = 0, idx = 0, shadow registers = 0.
  - seg_sel = 6'h3F, seg_data = 8'hFF, frame_done = 0.
- Divider (div_cnt):
  - Counts 0..DIV-1 and wraps to 0.
  - idx (0..5) increments when div_cnt = DIV-1; it wraps from 5 to 0.
- Frame latch:
  - On any cycle with div_cnt = 0 and idx = 0, the shadow registers capture digit_data, digit_en and dp_en.
  - This includes the first cycle after reset release.
  - frame_done is registered and is 1 exactly in the cycle after each capture.
  - Input changes at any other time have no visible effect until the next capture.
- Output stage is registered (1-cycle latency from div_cnt/idx):
  - If div_cnt < BLANK_CYC, or shadow_en[idx] = 0: seg_sel = 6'h3F and seg_data = 8'hFF.
  - Otherwise: seg_sel = ~(6'b1 << idx), and seg_data = {~shadow_dp[idx], dec7(shadow_nibble[idx])}.
- dec7 decode table, including bit 7 = 1 (dp off):
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
  - 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E
  - When dp is lit, bit 7 is cleared (e.g. 1 with dp = 79).
- Selection rules:
  - At most one seg_sel bit is ever low.
  - seg_sel and seg_data change in the same cycle, never split.
- Reset mid-frame: on the cycle after rst is sampled high, outputs are blank. After release the scan restarts at slot 0 with a fresh capture.
- Frame period is 6*DIV clocks; frame_done pulses once per frame.
- Implementation must not use division at run time: DIV is a localparam.

Test Plan:
Bench parameters: CLK_FREQ = 60, DIGIT_HZ = 10 (DIV = 6), BLANK_CYC = 1.
1. Reset: hold rst = 1 for 5 clocks with any inputs -> seg_sel = 3F, seg_data = FF, frame_done = 0 throughout.
2. Normal scan: release rst with digit_data = 24'h543210, digit_en = 3F, dp_en = 0.
   - frame_done pulses in the 2nd cycle after release, then every 36 clocks.
   - Each slot shows 1 blank cycle, then 5 cycles of:
     - seg_sel 3E / seg_data C0
     - 3D / F9
     - 3B / A4
     - 37 / B0
     - 2F / 99
     - 1F / 92
3. Mid-frame change: during slot 2, set digit_data = 24'hFEDCBA.
   - Slots 2-5 of the current frame still show A4, B0, 99, 92.
   - The next frame shows 88, 83, C6, A1, 86, 8E.
4. Enables and dp: digit_en = 6'b000011, dp_en = 6'b000010, digit_data = 24'h000010.
   - Slot 0: seg_sel 3E, seg_data C0.
   - Slot 1: seg_sel 3D, seg_data 79.
   - Slots 2-5: seg_sel 3F, seg_data FF for all 6 cycles.
5. Reset mid-operation: assert rst for 1 cycle during slot 3.
   - Next cycle: blank outputs.
   - After release: capture, frame_done pulse, scan restarts at slot 0 (seg_sel 3E after 1 blank cycle).
6. Invariant check over 10 frames of random inputs: never more than one seg_sel bit low, and seg_data = FF whenever seg_sel = 3F.
